// File: rtl/csr_ctrl_pkg.sv
// csr_ctrl_pkg: shared definitions for the CSR sequencer.
//   - CSR addresses of the machine-mode registers handled by the sequencer
//   - mstatus bit positions (MIE, MPIE, MPP)
//   - request-type, CSR-op and sequencer state encodings
//   - is_known_csr(): true for the four CSRs the register file implements
package csr_ctrl_pkg;

    localparam logic [11:0] MSTATUS_ADDR = 12'h300;
    localparam logic [11:0] MTVEC_ADDR   = 12'h305;
    localparam logic [11:0] MEPC_ADDR    = 12'h341;
    localparam logic [11:0] MCAUSE_ADDR  = 12'h342;

    localparam int unsigned MSTATUS_MIE    = 3;
    localparam int unsigned MSTATUS_MPIE   = 7;
    localparam int unsigned MSTATUS_MPP_HI = 12;
    localparam int unsigned MSTATUS_MPP_LO = 11;

    typedef enum logic [1:0] {
        REQ_CSR   = 2'd0,
        REQ_ECALL = 2'd1,
        REQ_MRET  = 2'd2,
        REQ_RSVD  = 2'd3
    } req_type_t;

    typedef enum logic [1:0] {
        OP_NONE = 2'd0,
        OP_RW   = 2'd1,
        OP_RS   = 2'd2,
        OP_RC   = 2'd3
    } csr_op_t;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CSR,
        ST_T_EPC,
        ST_T_CAUSE,
        ST_T_STAT,
        ST_T_VEC,
        ST_R_STAT,
        ST_R_EPC
    } state_t;

    function automatic logic is_known_csr(input logic [11:0] addr);
        return (addr == MSTATUS_ADDR) || (addr == MTVEC_ADDR) ||
               (addr == MEPC_ADDR)    || (addr == MCAUSE_ADDR);
    endfunction

endpackage

// File: rtl/csr_alu.sv
// csr_alu: combinational read-modify-write datapath for CSR instructions.
// Ports:
//   i_op             CSR operation (RW / RS / RC, 0 = read only)
//   i_old            current CSR value
//   i_src            rs1 value or zero-extended immediate
//   o_new            value to write back
//   o_write_suppress 1 when the instruction must not write (read-only op,
//                    or RS/RC with a zero source)
module csr_alu
    import csr_ctrl_pkg::*;
#(
    parameter int unsigned WIDTH_SIZE = 32
) (
    input  logic [1:0]            i_op,
    input  logic [WIDTH_SIZE-1:0] i_old,
    input  logic [WIDTH_SIZE-1:0] i_src,
    output logic [WIDTH_SIZE-1:0] o_new,
    output logic                  o_write_suppress
);

    always_comb begin
        o_new            = i_old;
        o_write_suppress = 1'b0;
        case (csr_op_t'(i_op))
            OP_RW: begin
                o_new = i_src;
            end
            OP_RS: begin
                o_new            = i_old | i_src;
                o_write_suppress = (i_src == '0);
            end
            OP_RC: begin
                o_new            = i_old & ~i_src;
                o_write_suppress = (i_src == '0);
            end
            default: begin
                o_write_suppress = 1'b1;
            end
        endcase
    end

endmodule

// File: rtl/csr_ctrl.sv
// csr_ctrl: sequencer/arbiter in front of the single-port CSR register file.
// Accepts a CSR instruction, an ecall trap entry or an mret trap return and
// walks the CSR file through the required read/write sequence.
// Ports:
//   clk_i, rst_i                  clock, async active-high reset
//   req_valid_i, req_type_i       request handshake (sampled while ready_o)
//   csr_op_i, csr_addr_i, csr_src_i, pc_i   request payload
//   ready_o                       idle, request may be accepted
//   done_o, rd_data_o             CSR instruction complete + old CSR value
//   redirect_valid_o, redirect_pc_o   trap entry/return fetch redirect
//   csr_wen_o, csr_waddr_o, csr_wdata_o, csr_raddr_o   to CSR file
//   csr_rdata_i                   combinational read data from CSR file
module csr_ctrl
    import csr_ctrl_pkg::*;
#(
    parameter int unsigned            WIDTH_SIZE  = 32,
    parameter logic [WIDTH_SIZE-1:0]  ECALL_CAUSE = WIDTH_SIZE'(11)
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  req_valid_i,
    input  logic [1:0]            req_type_i,
    input  logic [1:0]            csr_op_i,
    input  logic [11:0]           csr_addr_i,
    input  logic [WIDTH_SIZE-1:0] csr_src_i,
    input  logic [WIDTH_SIZE-1:0] pc_i,
    output logic                  ready_o,
    output logic                  done_o,
    output logic [WIDTH_SIZE-1:0] rd_data_o,
    output logic                  redirect_valid_o,
    output logic [WIDTH_SIZE-1:0] redirect_pc_o,
    output logic                  csr_wen_o,
    output logic [WIDTH_SIZE-1:0] csr_waddr_o,
    output logic [WIDTH_SIZE-1:0] csr_wdata_o,
    output logic [WIDTH_SIZE-1:0] csr_raddr_o,
    input  logic [WIDTH_SIZE-1:0] csr_rdata_i
);

    function automatic logic [WIDTH_SIZE-1:0] addr_ext(input logic [11:0] a);
        return {{(WIDTH_SIZE-12){1'b0}}, a};
    endfunction

    state_t                r_state;
    state_t                w_state_next;
    logic [1:0]            r_op;
    logic [11:0]           r_addr;
    logic [WIDTH_SIZE-1:0] r_src;
    logic [WIDTH_SIZE-1:0] r_pc;

    logic [WIDTH_SIZE-1:0] w_alu_new;
    logic                  w_alu_suppress;
    logic                  w_addr_known;
    logic [WIDTH_SIZE-1:0] w_rd_val;
    logic [WIDTH_SIZE-1:0] w_target;
    logic [WIDTH_SIZE-1:0] w_stat_trap;
    logic [WIDTH_SIZE-1:0] w_stat_mret;

    csr_alu #(
        .WIDTH_SIZE (WIDTH_SIZE)
    ) u_alu (
        .i_op             (r_op),
        .i_old            (csr_rdata_i),
        .i_src            (r_src),
        .o_new            (w_alu_new),
        .o_write_suppress (w_alu_suppress)
    );

    assign ready_o      = (r_state == ST_IDLE);
    assign w_addr_known = is_known_csr(r_addr);
    // The CSR file aliases unknown addresses onto mtvec, so reads are masked here.
    assign w_rd_val     = w_addr_known ? csr_rdata_i : '0;
    assign w_target     = {csr_rdata_i[WIDTH_SIZE-1:2], 2'b00};

    always_comb begin
        w_stat_trap                                 = csr_rdata_i;
        w_stat_trap[MSTATUS_MPIE]                   = csr_rdata_i[MSTATUS_MIE];
        w_stat_trap[MSTATUS_MIE]                    = 1'b0;
        w_stat_trap[MSTATUS_MPP_HI:MSTATUS_MPP_LO]  = 2'b11;

        w_stat_mret                                 = csr_rdata_i;
        w_stat_mret[MSTATUS_MIE]                    = csr_rdata_i[MSTATUS_MPIE];
        w_stat_mret[MSTATUS_MPIE]                   = 1'b1;
        w_stat_mret[MSTATUS_MPP_HI:MSTATUS_MPP_LO]  = 2'b11;
    end

    // State register
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Request capture
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_op   <= '0;
            r_addr <= '0;
            r_src  <= '0;
            r_pc   <= '0;
        end else if ((r_state == ST_IDLE) && req_valid_i) begin
            r_op   <= csr_op_i;
            r_addr <= csr_addr_i;
            r_src  <= csr_src_i;
            r_pc   <= pc_i;
        end
    end

    // Next-state logic
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_IDLE: begin
                if (req_valid_i) begin
                    case (req_type_t'(req_type_i))
                        REQ_CSR:   w_state_next = ST_CSR;
                        REQ_ECALL: w_state_next = ST_T_EPC;
                        REQ_MRET:  w_state_next = ST_R_STAT;
                        default:   w_state_next = ST_IDLE;
                    endcase
                end
            end
            ST_CSR:     w_state_next = ST_IDLE;
            ST_T_EPC:   w_state_next = ST_T_CAUSE;
            ST_T_CAUSE: w_state_next = ST_T_STAT;
            ST_T_STAT:  w_state_next = ST_T_VEC;
            ST_T_VEC:   w_state_next = ST_IDLE;
            ST_R_STAT:  w_state_next = ST_R_EPC;
            ST_R_EPC:   w_state_next = ST_IDLE;
            default:    w_state_next = ST_IDLE;
        endcase
    end

    // CSR-file side outputs
    always_comb begin
        csr_wen_o   = 1'b0;
        csr_waddr_o = '0;
        csr_wdata_o = '0;
        csr_raddr_o = '0;
        case (r_state)
            ST_CSR: begin
                csr_raddr_o = addr_ext(r_addr);
                csr_waddr_o = addr_ext(r_addr);
                csr_wdata_o = w_alu_new;
                csr_wen_o   = w_addr_known && !w_alu_suppress;
            end
            ST_T_EPC: begin
                csr_wen_o   = 1'b1;
                csr_waddr_o = addr_ext(MEPC_ADDR);
                csr_wdata_o = r_pc;
            end
            ST_T_CAUSE: begin
                csr_wen_o   = 1'b1;
                csr_waddr_o = addr_ext(MCAUSE_ADDR);
                csr_wdata_o = ECALL_CAUSE;
            end
            ST_T_STAT: begin
                csr_raddr_o = addr_ext(MSTATUS_ADDR);
                csr_wen_o   = 1'b1;
                csr_waddr_o = addr_ext(MSTATUS_ADDR);
                csr_wdata_o = w_stat_trap;
            end
            ST_T_VEC: begin
                csr_raddr_o = addr_ext(MTVEC_ADDR);
            end
            ST_R_STAT: begin
                csr_raddr_o = addr_ext(MSTATUS_ADDR);
                csr_wen_o   = 1'b1;
                csr_waddr_o = addr_ext(MSTATUS_ADDR);
                csr_wdata_o = w_stat_mret;
            end
            ST_R_EPC: begin
                csr_raddr_o = addr_ext(MEPC_ADDR);
            end
            default: ;
        endcase
    end

    // Registered responses, sampled at the final state's edge
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            done_o           <= 1'b0;
            rd_data_o        <= '0;
            redirect_valid_o <= 1'b0;
            redirect_pc_o    <= '0;
        end else begin
            done_o           <= 1'b0;
            redirect_valid_o <= 1'b0;
            case (r_state)
                ST_CSR: begin
                    done_o    <= 1'b1;
                    rd_data_o <= w_rd_val;
                end
                ST_T_VEC, ST_R_EPC: begin
                    redirect_valid_o <= 1'b1;
                    redirect_pc_o    <= w_target;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_csr_ctrl.sv
module tb_csr_ctrl;

    logic        clk_i;
    logic        rst_i;
    logic        req_valid_i;
    logic [1:0]  req_type_i;
    logic [1:0]  csr_op_i;
    logic [11:0] csr_addr_i;
    logic [31:0] csr_src_i;
    logic [31:0] pc_i;
    logic        ready_o;
    logic        done_o;
    logic [31:0] rd_data_o;
    logic        redirect_valid_o;
    logic [31:0] redirect_pc_o;
    logic        csr_wen_o;
    logic [31:0] csr_waddr_o;
    logic [31:0] csr_wdata_o;
    logic [31:0] csr_raddr_o;
    logic [31:0] csr_rdata_i;

    csr_ctrl #(
        .WIDTH_SIZE  (32),
        .ECALL_CAUSE (32'd11)
    ) dut (
        .clk_i            (clk_i),
        .rst_i            (rst_i),
        .req_valid_i      (req_valid_i),
        .req_type_i       (req_type_i),
        .csr_op_i         (csr_op_i),
        .csr_addr_i       (csr_addr_i),
        .csr_src_i        (csr_src_i),
        .pc_i             (pc_i),
        .ready_o          (ready_o),
        .done_o           (done_o),
        .rd_data_o        (rd_data_o),
        .redirect_valid_o (redirect_valid_o),
        .redirect_pc_o    (redirect_pc_o),
        .csr_wen_o        (csr_wen_o),
        .csr_waddr_o      (csr_waddr_o),
        .csr_wdata_o      (csr_wdata_o),
        .csr_raddr_o      (csr_raddr_o),
        .csr_rdata_i      (csr_rdata_i)
    );

    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    // CSR register file environment: unknown addresses alias onto mtvec.
    logic [31:0] f_mstatus, f_mtvec, f_mepc, f_mcause;
    logic        bd_we;
    logic [1:0]  bd_sel;
    logic [31:0] bd_val;

    always_comb begin
        case (csr_raddr_o)
            32'h300: csr_rdata_i = f_mstatus;
            32'h341: csr_rdata_i = f_mepc;
            32'h342: csr_rdata_i = f_mcause;
            default: csr_rdata_i = f_mtvec;
        endcase
    end

    always @(posedge clk_i) begin
        if (bd_we) begin
            case (bd_sel)
                2'd0: f_mstatus <= bd_val;
                2'd1: f_mtvec   <= bd_val;
                2'd2: f_mepc    <= bd_val;
                default: f_mcause <= bd_val;
            endcase
        end else if (csr_wen_o) begin
            case (csr_waddr_o)
                32'h300: f_mstatus <= csr_wdata_o;
                32'h341: f_mepc    <= csr_wdata_o;
                32'h342: f_mcause  <= csr_wdata_o;
                default: f_mtvec   <= csr_wdata_o;
            endcase
        end
    end

    // Architectural reference state
    logic [31:0] m_mstatus, m_mtvec, m_mepc, m_mcause;

    int unsigned vectors;
    int unsigned miscompares;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic compare_file();
        chk("mstatus", f_mstatus, m_mstatus);
        chk("mtvec",   f_mtvec,   m_mtvec);
        chk("mepc",    f_mepc,    m_mepc);
        chk("mcause",  f_mcause,  m_mcause);
    endtask

    // Called at a negedge while idle.
    task automatic preload(input logic [1:0] sel, input logic [31:0] val);
        bd_we  = 1'b1;
        bd_sel = sel;
        bd_val = val;
        @(posedge clk_i);
        @(negedge clk_i);
        bd_we = 1'b0;
        case (sel)
            2'd0: m_mstatus = val;
            2'd1: m_mtvec   = val;
            2'd2: m_mepc    = val;
            default: m_mcause = val;
        endcase
    endtask

    function automatic logic [31:0] model_read(input logic [11:0] a);
        case (a)
            12'h300: return m_mstatus;
            12'h305: return m_mtvec;
            12'h341: return m_mepc;
            12'h342: return m_mcause;
            default: return 32'h0;
        endcase
    endfunction

    // Called at a negedge with ready_o expected high; returns at the negedge
    // of the response cycle, so consecutive calls run back-to-back.
    task automatic run_req(input logic [1:0] typ, input logic [1:0] op,
                           input logic [11:0] addr, input logic [31:0] src,
                           input logic [31:0] pc);
        logic [31:0] old_v, new_v, exp_rd, exp_pc;
        logic        legal, wr, got;
        int          exp_lat, exp_wr, cyc, writes;
        exp_rd = 0; exp_pc = 0; exp_wr = 0; exp_lat = 2;
        if (typ == 2'd0) begin
            legal = (addr == 12'h300) || (addr == 12'h305) || (addr == 12'h341) || (addr == 12'h342);
            old_v = model_read(addr);
            case (op)
                2'd1: new_v = src;
                2'd2: new_v = old_v | src;
                2'd3: new_v = old_v & ~src;
                default: new_v = old_v;
            endcase
            wr = legal && (op != 2'd0) && !((op != 2'd1) && (src == 32'h0));
            if (wr) begin
                case (addr)
                    12'h300: m_mstatus = new_v;
                    12'h305: m_mtvec   = new_v;
                    12'h341: m_mepc    = new_v;
                    default: m_mcause  = new_v;
                endcase
            end
            exp_rd = old_v; exp_wr = wr ? 1 : 0; exp_lat = 2;
        end else if (typ == 2'd1) begin
            m_mepc    = pc;
            m_mcause  = 32'd11;
            m_mstatus = (m_mstatus & ~32'h1888) | ((m_mstatus & 32'h8) << 4) | 32'h1800;
            exp_pc = m_mtvec & ~32'h3; exp_wr = 3; exp_lat = 5;
        end else begin
            m_mstatus = (m_mstatus & ~32'h1888) | ((m_mstatus & 32'h80) >> 4) | 32'h1880;
            exp_pc = m_mepc & ~32'h3; exp_wr = 1; exp_lat = 3;
        end

        chk("ready_idle", 32'(ready_o), 32'd1);
        req_valid_i = 1'b1;
        req_type_i  = typ;
        csr_op_i    = op;
        csr_addr_i  = addr;
        csr_src_i   = src;
        pc_i        = pc;
        @(posedge clk_i);
        @(negedge clk_i);
        cyc = 1; writes = 0; got = 1'b0;
        while (!got && cyc <= 8) begin
            if (done_o || redirect_valid_o) begin
                got = 1'b1;
            end else begin
                if (cyc == 1) chk("ready_busy", 32'(ready_o), 32'd0);
                if (csr_wen_o) writes++;
                // requests while busy must be ignored
                req_valid_i = 1'($urandom_range(0, 1));
                req_type_i  = 2'($urandom);
                csr_op_i    = 2'($urandom);
                csr_addr_i  = 12'($urandom);
                csr_src_i   = $urandom;
                pc_i        = $urandom;
                @(posedge clk_i);
                @(negedge clk_i);
                cyc++;
            end
        end
        req_valid_i = 1'b0;
        chk("pulse_seen", 32'(got), 32'd1);
        chk("latency", 32'(cyc), 32'(exp_lat));
        chk("write_count", 32'(writes), 32'(exp_wr));
        chk("done", 32'(done_o), 32'(typ == 2'd0));
        chk("redirect", 32'(redirect_valid_o), 32'(typ != 2'd0));
        chk("ready_pulse", 32'(ready_o), 32'd1);
        if (typ == 2'd0) chk("rd_data", rd_data_o, exp_rd);
        else             chk("redirect_pc", redirect_pc_o, exp_pc);
        compare_file();
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_ready"},    32'(ready_o), 32'd1);
        chk({tag, "_done"},     32'(done_o), 32'd0);
        chk({tag, "_redir"},    32'(redirect_valid_o), 32'd0);
        chk({tag, "_rd"},       rd_data_o, 32'd0);
        chk({tag, "_rpc"},      redirect_pc_o, 32'd0);
        chk({tag, "_wen"},      32'(csr_wen_o), 32'd0);
        chk({tag, "_waddr"},    csr_waddr_o, 32'd0);
        chk({tag, "_wdata"},    csr_wdata_o, 32'd0);
        chk({tag, "_raddr"},    csr_raddr_o, 32'd0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        logic [11:0] addr_tbl [6];
        logic [1:0]  typ;
        logic [11:0] a;
        logic [31:0] s;
        int          pick;

        addr_tbl[0] = 12'h300; addr_tbl[1] = 12'h305; addr_tbl[2] = 12'h341;
        addr_tbl[3] = 12'h342; addr_tbl[4] = 12'h7C0; addr_tbl[5] = 12'h000;
        vectors = 0; miscompares = 0;
        rst_i = 1'b1; req_valid_i = 1'b0; req_type_i = '0; csr_op_i = '0;
        csr_addr_i = '0; csr_src_i = '0; pc_i = '0;
        bd_we = 1'b0; bd_sel = '0; bd_val = '0;
        repeat (2) @(negedge clk_i);
        check_reset_outputs("reset");
        rst_i = 1'b0;

        preload(2'd0, 32'h0);
        preload(2'd1, 32'h0000_0004);
        preload(2'd2, 32'h0);
        preload(2'd3, 32'h0);

        // RW mtvec, then read back with RS src 0 (no write)
        run_req(2'd0, 2'd1, 12'h305, 32'h8000_0100, 32'h0);
        run_req(2'd0, 2'd2, 12'h305, 32'h0, 32'h0);
        chk("rs_readback", rd_data_o, 32'h8000_0100);

        // RS / RC on mstatus
        run_req(2'd0, 2'd2, 12'h300, 32'h8, 32'h0);
        chk("rs_mstatus", f_mstatus, 32'h8);
        run_req(2'd0, 2'd3, 12'h300, 32'h8, 32'h0);
        chk("rc_mstatus", f_mstatus, 32'h0);

        // ecall
        preload(2'd1, 32'h8000_0103);
        preload(2'd0, 32'h8);
        run_req(2'd1, 2'd0, 12'h0, 32'h0, 32'h8000_0040);
        chk("ecall_mstatus", f_mstatus, 32'h1880);
        chk("ecall_pc", redirect_pc_o, 32'h8000_0100);

        // mret
        preload(2'd2, 32'h8000_0044);
        run_req(2'd2, 2'd0, 12'h0, 32'h0, 32'h0);
        chk("mret_mstatus", f_mstatus, 32'h1888);
        chk("mret_pc", redirect_pc_o, 32'h8000_0044);

        // illegal address
        run_req(2'd0, 2'd1, 12'h7C0, 32'hFFFF_FFFF, 32'h0);

        // reserved request type: no response
        req_valid_i = 1'b1; req_type_i = 2'd3;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk_i);
            @(negedge clk_i);
            chk("rsvd_ready", 32'(ready_o), 32'd1);
            chk("rsvd_quiet", 32'({done_o, redirect_valid_o, csr_wen_o}), 32'd0);
        end
        req_valid_i = 1'b0;
        compare_file();

        // reset during T_CAUSE
        preload(2'd3, 32'hDEAD_0000);
        req_valid_i = 1'b1; req_type_i = 2'd1; pc_i = 32'h8000_0080;
        @(posedge clk_i);
        @(negedge clk_i);
        req_valid_i = 1'b0;
        @(posedge clk_i);
        @(negedge clk_i);
        chk("tcause_waddr", csr_waddr_o, 32'h342);
        rst_i = 1'b1;
        #1;
        check_reset_outputs("midrst");
        @(posedge clk_i);
        @(negedge clk_i);
        rst_i = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(posedge clk_i);
            @(negedge clk_i);
            chk("postrst_quiet", 32'({redirect_valid_o, csr_wen_o, ready_o}), 32'd1);
        end
        m_mepc = 32'h8000_0080;
        compare_file();
        run_req(2'd0, 2'd1, 12'h342, 32'h0000_0007, 32'h0);

        // randomized traffic
        for (int i = 0; i < 150; i++) begin
            if ($urandom_range(0, 9) == 0) preload(2'($urandom), $urandom);
            pick = int'($urandom_range(0, 9));
            typ  = (pick <= 5) ? 2'd0 : (pick <= 7) ? 2'd1 : (pick == 8) ? 2'd2 : 2'd3;
            a    = ($urandom_range(0, 7) == 0) ? 12'($urandom) : addr_tbl[$urandom_range(0, 5)];
            s    = ($urandom_range(0, 3) == 0) ? 32'h0 : $urandom;
            if (typ == 2'd3) begin
                req_valid_i = 1'b1; req_type_i = 2'd3;
                @(posedge clk_i);
                @(negedge clk_i);
                req_valid_i = 1'b0;
                chk("rnd_rsvd", 32'({ready_o, done_o, redirect_valid_o}), 32'd4);
            end else begin
                run_req(typ, 2'($urandom), a, s, $urandom);
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
